// File: rtl/motor_cmd_tx.sv
// Motor command transmitter: packs {stop, dir, speed} into a tagged command byte,
// queues it, and sends each byte as a UART frame paced by an external bit-rate tick.
module motor_cmd_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       baud_tick,
  input  logic [2:0] speed,
  input  logic       dir,
  input  logic       stop,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       TX,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic        full, empty, push, pop, load, done;
  logic [7:0]  head;

  logic [2:0]  state, state_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  cnt, cnt_n;
  logic        scnt, scnt_n;
  logic        par, par_n;
  logic        tx_n;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign wr_ptr_n  = wr_ptr + (AW+1)'(push);
  assign rd_ptr_n  = rd_ptr + (AW+1)'(pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {stop, dir, 3'b010, speed};
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    scnt_n  = scnt;
    par_n   = par;
    tx_n    = TX;
    load    = 1'b0;
    done    = 1'b0;
    if (baud_tick) begin
      case (state)
        S_IDLE:  load = !empty;
        S_START: begin
          tx_n    = shift[0];
          cnt_n   = 3'd0;
          state_n = S_DATA;
        end
        S_DATA: begin
          if (cnt == 3'd7) begin
            scnt_n = 1'b0;
            if (PARITY != 0) begin
              tx_n    = par;
              state_n = S_PAR;
            end else begin
              tx_n    = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            cnt_n   = cnt + 3'd1;
          end
        end
        S_PAR: begin
          tx_n    = 1'b1;
          scnt_n  = 1'b0;
          state_n = S_STOP;
        end
        S_STOP: begin
          if (scnt == 1'(STOP_BITS - 1)) begin
            done = 1'b1;
            if (!empty) begin
              load = 1'b1;
            end else begin
              tx_n    = 1'b1;
              state_n = S_IDLE;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        default: begin
          tx_n    = 1'b1;
          state_n = S_IDLE;
        end
      endcase
    end
    // Parity is captured at pop time so the shifter can consume the byte freely.
    if (load) begin
      shift_n = head;
      par_n   = (PARITY == 2) ? ~^head : ^head;
      tx_n    = 1'b0;
      state_n = S_START;
    end
  end

  assign pop = load;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= S_IDLE;
      shift       <= '0;
      cnt         <= '0;
      scnt        <= 1'b0;
      par         <= 1'b0;
      TX          <= 1'b1;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      state  <= state_n;
      shift  <= shift_n;
      cnt    <= cnt_n;
      scnt   <= scnt_n;
      par    <= par_n;
      TX     <= tx_n;
      busy   <= (state_n != S_IDLE) || (wr_ptr_n != rd_ptr_n);
      if (done) frames_sent <= frames_sent + 8'd1;
    end
  end

endmodule

// File: doc/motor_cmd_tx.md
Name: motor_cmd_tx

Overview:
Command-side counterpart of the motor command decoder. Packs a {speed, dir, stop} motor command into the fixed command byte and queues it in a small FIFO. Serialises each byte as an asynchronous UART frame on TX, paced by an external one-cycle bit-rate tick from the clock divider. Lets a console or master board drive the remote motor over the same serial link the motor board receives on.

Parameters:
FIFO_DEPTH, 4, command queue entries; power of two, 2..16
PARITY, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
CLK  input  1  system clock, all logic on posedge
RST_N  input  1  asynchronous active-low reset
baud_tick  input  1  one-CLK-wide pulse per bit period, synchronous to CLK
speed  input  3  commanded speed code
dir  input  1  commanded direction
stop  input  1  stop request
cmd_valid  input  1  command present on speed/dir/stop
cmd_ready  output  1  FIFO can accept (= !full, combinational)
TX  output  1  serial line, idle high
busy  output  1  frame in progress or FIFO non-empty
frames_sent  output  8  count of completed frames, wraps 255->0

Behaviour:
- Reset (async, RST_N low): TX=1, busy=0, frames_sent=0, FIFO empty, cmd_ready=1, FSM=IDLE. Asserting reset mid-frame aborts the frame immediately; TX returns high within the reset assertion.
- Encoding: byte[7]=stop, byte[6]=dir, byte[5:3]=3'b010 (tag), byte[2:0]=speed.
- Push: byte written when cmd_valid && cmd_ready at a CLK edge. cmd_valid while full is ignored and nothing is lost from the queue.
- Same-edge push and pop is legal whenever not full; occupancy is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX=1. On baud_tick with FIFO non-empty, pop head into shift register, TX<=0, go to START.
  - START: on baud_tick, TX<=shift[0], bit counter=0, go to DATA.
  - DATA: on each baud_tick, shift right and increment the counter. After the 8th data bit has been held one tick:
    - with PARITY!=0, TX<=parity bit and go to PARITY;
    - otherwise TX<=1 and go to STOP.
  - PARITY: on baud_tick, TX<=1, go to STOP.
  - STOP: holds STOP_BITS tick periods, then on the closing baud_tick:
    - frames_sent increments;
    - if the FIFO is non-empty, pop, TX<=0 and go to START (back-to-back, no idle bit);
    - otherwise go to IDLE.
- Parity: even = XOR of the data bits; odd = its inverse.
- Each line bit lasts exactly one baud_tick interval. Bit changes occur on the CLK edge where baud_tick=1. Frame start latency after push into an empty idle queue is up to one tick period.
- Data is sent LSB first.
- busy = (state!=IDLE) || !empty. It is registered with the FSM and goes low on the same edge the FSM returns to IDLE.
- baud_tick is ignored in no state; a tick always advances exactly one bit.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

Test Plan:
- Reset then idle: hold RST_N=0, then release; apply 20 baud_ticks with no cmd_valid -> TX stays 1, busy=0, frames_sent=0, cmd_ready=1.
- Single frame, PARITY=1: push speed=5, dir=1, stop=0 (byte 0x55) -> TX per tick is 0,1,0,1,0,1,0,1,0,0,1 (start, data LSB first, parity 0, stop); frames_sent=1; busy falls after the stop bit.
- Back-to-back and wrap: with PARITY=0, push 0x55 then stop=1, dir=0, speed=0 (byte 0x90) -> the second start bit directly follows the first stop bit. Sending 256 frames leaves frames_sent=0.
- Full FIFO: push 5 commands in consecutive cycles with baud_tick held low -> cmd_ready falls after 4 and the 5th is dropped. Exactly 4 frames emerge, in push order.
- Odd parity and 2 stop bits: PARITY=2, STOP_BITS=2, byte 0x57 (five ones) -> parity bit 0, followed by two stop-bit intervals of 1.
- Reset mid-frame: assert RST_N during DATA bit 3 -> TX=1 immediately, FIFO emptied, frames_sent=0. After release, the next push sends a complete, correct frame.
